// File: rtl/mem_pkg.sv
// Shared widths and FSM encoding for the data-cache main-memory responder.
package mem_pkg;
  localparam int LINE_W  = 128;
  localparam int LADDR_W = 26;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;
endpackage

// File: rtl/mem_line_array.sv
// Line store: one access slot per cycle carrying an optional write and an optional read.
// A read that hits the index being written on the same edge returns the new line.
module mem_line_array
  import mem_pkg::*;
#(
  parameter int INDEX_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [LINE_W-1:0]  wr_data,
  input  logic               rd_en,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic [LINE_W-1:0]  rd_data
);
  logic [LINE_W-1:0] mem [2**INDEX_W];

  // Storage is deliberately not reset.
  always_ff @(posedge clk)
    if (wr_en) mem[wr_idx] <= wr_data;

  always_ff @(posedge clk or posedge reset)
    if (reset)
      rd_data <= '0;
    else if (rd_en)
      rd_data <= (wr_en && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];
endmodule

// File: rtl/data_main_memory.sv
// Fixed-latency line memory behind the data cache: fill plus optional victim write-back
// as one transaction, completing with registered response pulses.
module data_main_memory
  import mem_pkg::*;
#(
  parameter int LATENCY = 5,
  parameter int INDEX_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               reqD_mem,
  input  logic [LADDR_W-1:0] reqAddrD_mem,
  input  logic               reqD_cache_write,
  input  logic [LADDR_W-1:0] reqAddrD_write_mem,
  input  logic [LINE_W-1:0]  data_to_mem,
  input  logic               reqD_stop,
  output logic [LINE_W-1:0]  data_from_mem,
  output logic               read_ready_from_mem,
  output logic               written_data_ack,
  output logic               busy
);
  mem_state_t          state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                fill_q, wr_q, armed;
  logic [INDEX_W-1:0]  ridx_q, widx_q;
  logic [LINE_W-1:0]   wdata_q;
  logic                req_any, accept, fire;

  // Upper line-address bits alias onto the same storage.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{reqAddrD_mem[LADDR_W-1:INDEX_W], reqAddrD_write_mem[LADDR_W-1:INDEX_W]};

  assign req_any = reqD_mem | reqD_cache_write;
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    fire      = 1'b0;
    case (state)
      IDLE: if (req_any && armed) begin
        accept    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (!reqD_stop && (cnt == '0)) begin
        fire      = 1'b1;
        state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;

  always_ff @(posedge clk or posedge reset)
    if (reset)
      cnt <= '0;
    else if (accept)
      cnt <= CNT_W'(LATENCY - 1);
    else if ((state == WAIT) && !reqD_stop && (cnt != '0))
      cnt <= cnt - 1'b1;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fill_q  <= 1'b0;
      wr_q    <= 1'b0;
      ridx_q  <= '0;
      widx_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      fill_q  <= reqD_mem;
      wr_q    <= reqD_cache_write;
      ridx_q  <= reqAddrD_mem[INDEX_W-1:0];
      widx_q  <= reqAddrD_write_mem[INDEX_W-1:0];
      wdata_q <= data_to_mem;
    end

  // A request level still high after completion must drop for one edge before re-arming.
  always_ff @(posedge clk or posedge reset)
    if (reset)
      armed <= 1'b1;
    else if (state == RESP)
      armed <= 1'b0;
    else if ((state == IDLE) && !req_any)
      armed <= 1'b1;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      read_ready_from_mem <= 1'b0;
      written_data_ack    <= 1'b0;
    end else begin
      read_ready_from_mem <= fire & fill_q;
      written_data_ack    <= fire & wr_q;
    end

  mem_line_array #(.INDEX_W(INDEX_W)) u_array (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fire & wr_q),
    .wr_idx  (widx_q),
    .wr_data (wdata_q),
    .rd_en   (fire & fill_q),
    .rd_idx  (ridx_q),
    .rd_data (data_from_mem)
  );
endmodule

// File: tb/tb_data_main_memory.sv
// Scoreboard bench: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_data_main_memory;
  localparam int LAT = 5;
  localparam int IW  = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         reqD_mem = 1'b0;
  logic [25:0]  reqAddrD_mem = '0;
  logic         reqD_cache_write = 1'b0;
  logic [25:0]  reqAddrD_write_mem = '0;
  logic [127:0] data_to_mem = '0;
  logic         reqD_stop = 1'b0;
  logic [127:0] data_from_mem;
  logic         read_ready_from_mem;
  logic         written_data_ack;
  logic         busy;

  data_main_memory #(.LATENCY(LAT), .INDEX_W(IW)) dut (
    .clk                (clk),
    .reset              (reset),
    .reqD_mem           (reqD_mem),
    .reqAddrD_mem       (reqAddrD_mem),
    .reqD_cache_write   (reqD_cache_write),
    .reqAddrD_write_mem (reqAddrD_write_mem),
    .data_to_mem        (data_to_mem),
    .reqD_stop          (reqD_stop),
    .data_from_mem      (data_from_mem),
    .read_ready_from_mem(read_ready_from_mem),
    .written_data_ack   (written_data_ack),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           t;
    bit           f;
    bit           w;
    logic [127:0] d;
  } exp_t;

  exp_t         sbq[$];
  logic [127:0] mdl [2**IW];
  int           n_cmp = 0;
  int           n_bad = 0;

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && (read_ready_from_mem || written_data_ack)) begin
      if (sbq.size() == 0) begin
        chk("spurious_pulse", {read_ready_from_mem, written_data_ack}, 2'b00);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("resp_cycle", 128'(cyc), 128'(e.t));
        chk("read_ready", 128'(read_ready_from_mem), 128'(e.f));
        chk("wr_ack", 128'(written_data_ack), 128'(e.w));
        if (e.f) chk("fill_data", data_from_mem, e.d);
      end
    end
  end

  // Issue one transaction starting at a negedge; returns at a negedge with requests low
  // long enough for the responder to re-arm.
  task automatic do_txn(input bit f, input bit w, input logic [25:0] ra, input logic [25:0] wa,
                        input logic [127:0] wd, input int stall_k, input int stall_n,
                        input int hold);
    int   acc;
    bit   got;
    exp_t e;
    reqD_mem           = f;
    reqD_cache_write   = w;
    reqAddrD_mem       = ra;
    reqAddrD_write_mem = wa;
    data_to_mem        = wd;
    acc = cyc + 1;
    if (w) mdl[wa[IW-1:0]] = wd;
    e.t = acc + LAT + stall_n;
    e.f = f;
    e.w = w;
    e.d = mdl[ra[IW-1:0]];
    sbq.push_back(e);
    got = 0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (read_ready_from_mem || written_data_ack) begin
        got = 1;
      end else begin
        chk("busy_in_flight", 128'(busy), 128'(1));
        // Inputs are latched at acceptance; later changes must be ignored.
        reqAddrD_mem       = 26'($urandom);
        reqAddrD_write_mem = 26'($urandom);
        data_to_mem        = {$urandom, $urandom, $urandom, $urandom};
        if (stall_n > 0 && cyc == acc + stall_k) reqD_stop = 1'b1;
        if (stall_n > 0 && cyc == acc + stall_k + stall_n) reqD_stop = 1'b0;
      end
    end
    if (!got) chk("resp_timeout", 128'(0), 128'(1));
    reqD_stop = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      chk("no_retrigger_busy", 128'(busy), 128'(0));
    end
    reqD_mem         = 1'b0;
    reqD_cache_write = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic abort_txn(input logic [25:0] wa, input logic [127:0] wd);
    reqD_mem           = 1'b1;
    reqD_cache_write   = 1'b1;
    reqAddrD_mem       = wa;
    reqAddrD_write_mem = wa;
    data_to_mem        = wd;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_read_ready", 128'(read_ready_from_mem), 128'(0));
    chk("abort_ack", 128'(written_data_ack), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_data", data_from_mem, 128'(0));
    @(negedge clk);
    reqD_mem         = 1'b0;
    reqD_cache_write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [127:0] dead, nd, la, lb;
    logic [25:0]  ra, wa;
    bit           f, w;
    int           sk, sn;
    for (int i = 0; i < 2**IW; i++) mdl[i] = '0;
    dead = {4{32'hDEADBEEF}};

    repeat (3) @(negedge clk);
    chk("rst_read_ready", 128'(read_ready_from_mem), 128'(0));
    chk("rst_ack", 128'(written_data_ack), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_data", data_from_mem, 128'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 128'(busy), 128'(0));

    // Fill of an untouched line.
    do_txn(1, 0, 26'h0000010, 26'h0, '0, 0, 0, 0);
    // Write-back plus fill, then read back the written line.
    do_txn(1, 1, 26'h0000040, 26'h0000025, dead, 0, 0, 0);
    do_txn(1, 0, 26'h0000025, 26'h0, '0, 0, 0, 0);
    // Write and fill hitting the same index through an aliased address.
    nd = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    do_txn(1, 1, 26'h0000025, 26'h0000025 + 26'(2**IW), nd, 0, 0, 0);
    // Three-cycle stall in WAIT.
    do_txn(1, 0, 26'h0000025, 26'h0, '0, 2, 3, 0);
    // Request held two cycles past the pulse, then a normal one.
    do_txn(1, 0, 26'h0000040, 26'h0, '0, 0, 0, 2);
    do_txn(1, 0, 26'h0000010, 26'h0, '0, 0, 0, 0);
    // Write-only, then aborted write to the same line, then read back old data.
    la = 128'hAAAA_5555_0000_FFFF_1234_5678_9ABC_DEF0;
    lb = 128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB;
    do_txn(0, 1, 26'h0, 26'h0000077, la, 0, 0, 0);
    do_txn(1, 0, 26'h0000025, 26'h0, '0, 0, 0, 0);
    abort_txn(26'h0000077, lb);
    do_txn(1, 0, 26'h0000077, 26'h0, '0, 0, 0, 0);

    // Randomized traffic over a small index window to force aliasing and reuse.
    for (int n = 0; n < 40; n++) begin
      f  = ($urandom_range(0, 3) != 0);
      w  = ($urandom_range(0, 1) == 1) || !f;
      ra = 26'($urandom);
      wa = 26'($urandom);
      ra[IW-1:0] = IW'($urandom_range(0, 15));
      wa[IW-1:0] = IW'($urandom_range(0, 15));
      sn = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      sk = $urandom_range(1, LAT - 1);
      do_txn(f, w, ra, wa, {$urandom, $urandom, $urandom, $urandom}, sk, sn,
             $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (LAT + 5) @(negedge clk);
    chk("scoreboard_drained", 128'(sbq.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/data_main_memory.md
# data_main_memory

Line-granular main-memory responder on the far side of the data cache's miss/write-back port. It accepts a 128-bit line fill request and an optional victim write-back request from the cache and answers after a fixed, programmable latency. Write-back and fill travel as one transaction, so the cache sees a single completion event. It sits between the data cache and the backing line store, and is the only agent driving `data_from_mem`, `read_ready_from_mem` and `written_data_ack`.

## Interface
Parameters:
- LATENCY, 5: cycles from request acceptance to response pulse; legal range 1..255.
- INDEX_W, 10: low line-address bits used to index storage; depth = 2^INDEX_W lines.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high.
- reqD_mem  in  1  line request (fill), level, held by the cache until `read_ready_from_mem`.
- reqAddrD_mem  in  26  fill line address.
- reqD_cache_write  in  1  a write-back accompanies this request.
- reqAddrD_write_mem  in  26  victim line address.
- data_to_mem  in  128  victim line data.
- reqD_stop  in  1  stall; freezes the latency counter.
- data_from_mem  out  128  fill data; valid only while `read_ready_from_mem`=1.
- read_ready_from_mem  out  1  one-cycle fill-complete pulse.
- written_data_ack  out  1  one-cycle write-back-complete pulse.
- busy  out  1  a transaction is in flight.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If `reqD_mem`=1 or `reqD_cache_write`=1 at a posedge, latch fill address, write address, write data and write flag.
  - Load the counter with LATENCY-1 and go to WAIT.
- WAIT:
  - Decrement the counter each posedge while `reqD_stop`=0.
  - When `reqD_stop`=1, hold the counter.
  - At counter=0 with `reqD_stop`=0, go to RESP.
- RESP, single cycle:
  - If the write flag is set, the write-back commits to the array first, at index `reqAddrD_write_mem[INDEX_W-1:0]`.
  - The fill read then uses index `reqAddrD_mem[INDEX_W-1:0]`, so a read that aliases the written index returns the new data.
  - Pulse `read_ready_from_mem` when the latched request had `reqD_mem`=1.
  - Pulse `written_data_ack` when the write flag was set.
  - Both pulses occur in the same cycle when both were requested.
  - Next state is IDLE.
- Write-only request (`reqD_cache_write`=1, `reqD_mem`=0): only `written_data_ack` pulses.
- Re-acceptance: IDLE accepts a new request only after seeing the request low for at least one posedge since the last RESP. This prevents a held-over level from re-triggering.
- Storage upper address bits (25:INDEX_W) are ignored, so the array aliases.
- Array contents are not cleared by reset. Simulation initial contents are zero.

## Timing
- Reset:
  - Outputs: `read_ready_from_mem`=0, `written_data_ack`=0, `busy`=0, `data_from_mem`=0.
  - FSM goes to IDLE and the counter to 0.
  - Reset mid-transaction aborts it: no pulse is issued and no write is committed.
- Acceptance at posedge T with no stall:
  - Response outputs are registered and high during the cycle after posedge T+LATENCY.
  - They drop at posedge T+LATENCY+1.
- `busy`: high from the posedge after acceptance through the RESP cycle inclusive.
- Stall: each cycle of `reqD_stop` during WAIT adds exactly one cycle of latency. A stall in RESP does not delay the pulse.
- LATENCY=1: WAIT lasts one cycle, so the response arrives 1 cycle after acceptance.
- Inputs sampled in IDLE only; changes during WAIT/RESP are ignored.
- `data_from_mem` holds its last value outside pulses.

## Structure
- Package `mem_pkg`:
  - LINE_W=128, LADDR_W=26.
  - FSM enum `mem_state_t` (IDLE, WAIT, RESP).
  - Counter width constant CNT_W=8.
- Sub-module `mem_line_array`: single-port synchronous line RAM, 2^INDEX_W x 128, with write-first ordering, instantiated once.
- Top holds the FSM, counter, latch registers and re-acceptance guard.

## Test plan
- Reset, then a fill request to line 0x0000010 (LATENCY=5) -> zero data and `read_ready_from_mem` high exactly 5 cycles after acceptance for 1 cycle; `written_data_ack` stays 0.
- Write-back of 0xDEADBEEF_...(128-bit) to line 0x25 combined with a fill of line 0x40 -> both pulses in the same cycle. A later fill of 0x25 returns the DEADBEEF line.
- Write-back and fill to the same index (0x25 and 0x25+2^INDEX_W) -> fill returns the newly written data.
- `reqD_stop` held for 3 cycles during WAIT -> response 8 cycles after acceptance; during the stall `busy`=1 and no pulse.
- `reqD_mem` held high for 2 cycles after the pulse -> no second transaction until the request drops, then a new one is accepted normally.
- Reset asserted asynchronously 2 cycles into a write-back -> outputs go to 0 immediately, no ack is issued, and a later read of that line shows the old data.
